// File: rtl/ifetch_cache_pkg.sv
// Shared defaults, address field positions and FSM encoding for the instruction fetch cache.
package ifetch_cache_pkg;

   localparam int NLINES_DEF  = 16;
   localparam int LINE_DW_DEF = 4;

   localparam int OFF_LSB = 3;
   localparam int OFF_W   = 2;
   localparam int IDX_LSB = 5;
   localparam int IDX_W   = 4;
   localparam int TAG_LSB = 9;
   localparam int TAG_W   = 23;

   typedef enum logic [2:0] {
      FLUSH     = 3'd0,
      IDLE      = 3'd1,
      MISS_REQ  = 3'd2,
      MISS_FILL = 3'd3,
      RESP      = 3'd4
   } state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
      logic [OFF_W-1:0] off;
   } fetch_addr_t;

   function automatic fetch_addr_t split_addr(input logic [63:0] a);
      return fetch_addr_t'(a[TAG_LSB+TAG_W-1:OFF_LSB]);
   endfunction

   function automatic logic [63:0] line_addr(input fetch_addr_t f);
      return {32'b0, f.tag, f.idx, {IDX_LSB{1'b0}}};
   endfunction

endpackage

// File: rtl/ram_64_64.sv
// 64 x 64-bit data array, one write port and one read port.
// Read latency 1 cycle (registered output, holds when re is low).
// No backpressure; write and read are accepted every cycle.
module ram_64_64 (
   input  logic        clk,
   input  logic        we,
   input  logic [5:0]  waddr,
   input  logic [63:0] wdata,
   input  logic        re,
   input  logic [5:0]  raddr,
   output logic [63:0] rdata
);

   logic [63:0] mem [64];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/ifetch_cache.sv
// Direct-mapped instruction fetch cache with line refill and invalidate-all.
// Hit latency 1 cycle; miss returns the requested beat the cycle after the last refill beat.
// im_req_ready drops on a miss, refill, response replay, flush or invalidate; refill beats have no backpressure.
module ifetch_cache
   import ifetch_cache_pkg::*;
#(
   parameter int NLINES  = NLINES_DEF,
   parameter int LINE_DW = LINE_DW_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] im_req_addr,
   input  logic        im_req_valid,
   output logic        im_req_ready,
   output logic [63:0] im_resp_rdata,
   output logic        im_resp_valid,
   input  logic        inv_req,
   output logic [63:0] bm_req_addr,
   output logic        bm_req_valid,
   input  logic        bm_req_ready,
   input  logic [63:0] bm_resp_rdata,
   input  logic        bm_resp_valid
);

   state_t           state_q, state_nxt;
   fetch_addr_t      cur, req_q;
   logic             pend_q, inv_pend_q;
   logic [OFF_W-1:0] beat_q;
   logic [IDX_W-1:0] flush_idx_q;
   logic [TAG_W-1:0] tag_q [NLINES];
   logic [NLINES-1:0] valid_q;
   logic [63:0]      cap_q, ram_rdata;
   logic             hit, miss, accept, fill_beat, last_beat, flush_done;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{im_req_addr[63:32], im_req_addr[2:0]};

   assign cur        = split_addr(im_req_addr);
   // pend_q marks the cycle after an accept, when the tag lookup resolves
   assign hit        = pend_q && valid_q[req_q.idx] && (tag_q[req_q.idx] == req_q.tag);
   assign miss       = pend_q && !hit;
   assign fill_beat  = (state_q == MISS_FILL) && bm_resp_valid;
   assign last_beat  = fill_beat && (beat_q == OFF_W'(LINE_DW - 1));
   assign flush_done = (flush_idx_q == IDX_W'(NLINES - 1));

   assign im_req_ready = (state_q == IDLE) && !inv_pend_q && !inv_req && !miss;
   assign accept       = im_req_valid && im_req_ready;

   ram_64_64 u_data (
      .clk   (clk),
      .we    (fill_beat),
      .waddr ({req_q.idx, beat_q}),
      .wdata (bm_resp_rdata),
      .re    (accept),
      .raddr ({cur.idx, cur.off}),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FLUSH;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         FLUSH:     if (flush_done) state_nxt = IDLE;
         IDLE: begin
            if (miss) begin
               state_nxt = MISS_REQ;
            end else if (inv_req) begin
               state_nxt = FLUSH;
            end
         end
         MISS_REQ:  if (bm_req_ready) state_nxt = MISS_FILL;
         MISS_FILL: if (last_beat) state_nxt = RESP;
         RESP:      state_nxt = (inv_pend_q || inv_req) ? FLUSH : IDLE;
         default:   state_nxt = FLUSH;
      endcase
   end

   always_comb begin
      im_resp_valid = 1'b0;
      im_resp_rdata = ram_rdata;
      bm_req_valid  = 1'b0;
      bm_req_addr   = line_addr(req_q);
      case (state_q)
         IDLE:     im_resp_valid = hit;
         MISS_REQ: bm_req_valid  = 1'b1;
         RESP: begin
            im_resp_valid = 1'b1;
            im_resp_rdata = cap_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= 1'b0;
         inv_pend_q  <= 1'b0;
         beat_q      <= '0;
         flush_idx_q <= '0;
      end else begin
         pend_q <= accept;
         if (accept) begin
            req_q <= cur;
         end
         if (state_q == FLUSH) begin
            valid_q[flush_idx_q] <= 1'b0;
            flush_idx_q          <= flush_done ? '0 : flush_idx_q + IDX_W'(1);
            inv_pend_q           <= 1'b0;
         end else if (inv_req && (state_q != IDLE || miss)) begin
            inv_pend_q <= 1'b1;
         end
         // the victim line goes invalid before refill so an abandoned fill never hits
         if (state_q == IDLE && miss) begin
            valid_q[req_q.idx] <= 1'b0;
         end
         if (fill_beat) begin
            beat_q <= last_beat ? '0 : beat_q + OFF_W'(1);
            if (beat_q == req_q.off) begin
               cap_q <= bm_resp_rdata;
            end
            if (last_beat) begin
               tag_q[req_q.idx]   <= req_q.tag;
               valid_q[req_q.idx] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ifetch_cache.sv
// Scoreboard bench for ifetch_cache: backing memory responder, response monitor, scenario tasks.
module tb_ifetch_cache;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] im_req_addr = '0;
   logic        im_req_valid = 1'b0;
   logic        im_req_ready;
   logic [63:0] im_resp_rdata;
   logic        im_resp_valid;
   logic        inv_req = 1'b0;
   logic [63:0] bm_req_addr;
   logic        bm_req_valid;
   logic        bm_req_ready = 1'b1;
   logic [63:0] bm_resp_rdata = '0;
   logic        bm_resp_valid = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int bm_reqs = 0;
   int resp_cnt = 0;
   int resp_cyc = 0;
   int prev_resp_cyc = 0;
   int last_beat_cyc = 0;
   logic [63:0] last_bm_addr = '0;
   logic [63:0] exp_q [$];

   ifetch_cache dut (
      .clk           (clk),
      .rst           (rst),
      .im_req_addr   (im_req_addr),
      .im_req_valid  (im_req_valid),
      .im_req_ready  (im_req_ready),
      .im_resp_rdata (im_resp_rdata),
      .im_resp_valid (im_resp_valid),
      .inv_req       (inv_req),
      .bm_req_addr   (bm_req_addr),
      .bm_req_valid  (bm_req_valid),
      .bm_req_ready  (bm_req_ready),
      .bm_resp_rdata (bm_resp_rdata),
      .bm_resp_valid (bm_resp_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hA5A5_0F0F, ~a};
   endfunction

   task automatic monitor();
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!rst && im_resp_valid === 1'b1) begin
            total++;
            resp_cnt++;
            prev_resp_cyc = resp_cyc;
            resp_cyc = cyc;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL resp_unexpected: got rdata=%h, required no response", im_resp_rdata);
            end else begin
               e = exp_q.pop_front();
               if (im_resp_rdata !== e) begin
                  bad++;
                  $display("FAIL resp_data: got %h, required %h", im_resp_rdata, e);
               end
            end
         end
      end
   endtask

   // One gap cycle after the request handshake, then LINE_DW ascending beats.
   task automatic responder();
      logic [31:0] la;
      forever begin
         @(negedge clk);
         if (!rst && bm_req_valid === 1'b1) begin
            la = bm_req_addr[31:0];
            last_bm_addr = bm_req_addr;
            bm_reqs++;
            @(negedge clk);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
               bm_resp_valid = 1'b1;
               bm_resp_rdata = mem_word(la + 32'(8 * i));
               if (i == 3) last_beat_cyc = cyc;
               @(negedge clk);
            end
            bm_resp_valid = 1'b0;
            bm_resp_rdata = '0;
         end
      end
   endtask

   task automatic fetch(input logic [31:0] a, input bit keep);
      int n;
      n = 0;
      im_req_addr = {32'h0, a};
      im_req_valid = 1'b1;
      #1;
      while (im_req_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      total++;
      if (n >= 200) begin
         bad++;
         $display("FAIL fetch_accept: addr=%h not accepted, ready=%b, required 1", a, im_req_ready);
         im_req_valid = 1'b0;
         return;
      end
      exp_q.push_back(mem_word({a[31:3], 3'b000}));
      @(negedge clk);
      if (!keep) im_req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int start, input string name);
      int n;
      n = 0;
      while (resp_cnt <= start && n < 300) begin
         @(negedge clk);
         #2;
         n++;
      end
      total++;
      if (n >= 300) begin
         bad++;
         $display("FAIL %s: response count %0d, required more than %0d", name, resp_cnt, start);
      end
   endtask

   task automatic wait_beat(input string name);
      int n;
      n = 0;
      while (bm_resp_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      total++;
      if (n >= 100) begin
         bad++;
         $display("FAIL %s: no refill beat seen, bm_resp_valid=%b, required 1", name, bm_resp_valid);
      end
   endtask

   task automatic count_low(output int n);
      n = 0;
      #1;
      while (im_req_ready !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (im_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b, required 0", im_req_ready); end
      total++;
      if (im_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b, required 0", im_resp_valid); end
      total++;
      if (bm_req_valid !== 1'b0) begin bad++; $display("FAIL reset_bm_valid: got %b, required 0", bm_req_valid); end
      rst = 1'b0;
      count_low(n);
      total++;
      if (n != 16) begin bad++; $display("FAIL reset_flush_len: ready low %0d cycles, required 16", n); end
      total++;
      if (im_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b, required 1", im_req_ready); end
   endtask

   task automatic test_cold_miss();
      int b0, r0;
      b0 = bm_reqs;
      r0 = resp_cnt;
      fetch(32'h8000_0000, 1'b0);
      wait_resp(r0, "cold_resp");
      total++;
      if (bm_reqs != b0 + 1) begin bad++; $display("FAIL cold_refills: got %0d, required %0d", bm_reqs - b0, 1); end
      total++;
      if (last_bm_addr !== 64'h8000_0000) begin bad++; $display("FAIL cold_bm_addr: got %h, required %h", last_bm_addr, 64'h8000_0000); end
      total++;
      if (resp_cyc != last_beat_cyc + 1) begin bad++; $display("FAIL cold_latency: resp cycle %0d, required %0d", resp_cyc, last_beat_cyc + 1); end
   endtask

   task automatic test_back_to_back();
      int b0, r0;
      b0 = bm_reqs;
      r0 = resp_cnt;
      fetch(32'h8000_0008, 1'b1);
      fetch(32'h8000_0010, 1'b0);
      wait_resp(r0 + 1, "b2b_resp");
      total++;
      if (bm_reqs != b0) begin bad++; $display("FAIL b2b_refills: got %0d, required 0", bm_reqs - b0); end
      total++;
      if (resp_cyc - prev_resp_cyc != 1) begin bad++; $display("FAIL b2b_spacing: got %0d cycles, required 1", resp_cyc - prev_resp_cyc); end
   endtask

   task automatic test_conflict();
      int b0, r0;
      b0 = bm_reqs;
      r0 = resp_cnt;
      fetch(32'h8000_0200, 1'b0);
      wait_resp(r0, "conflict_resp");
      total++;
      if (last_bm_addr !== 64'h8000_0200) begin bad++; $display("FAIL conflict_bm_addr: got %h, required %h", last_bm_addr, 64'h8000_0200); end
      fetch(32'h8000_0000, 1'b0);
      wait_resp(r0 + 1, "conflict_refetch_resp");
      total++;
      if (bm_reqs != b0 + 2) begin bad++; $display("FAIL conflict_refills: got %0d, required 2", bm_reqs - b0); end
   endtask

   task automatic test_inv_during_fill();
      int b0, r0, n;
      b0 = bm_reqs;
      r0 = resp_cnt;
      fetch(32'h8000_0118, 1'b0);
      wait_beat("inv_fill_beat");
      inv_req = 1'b1;
      @(negedge clk);
      inv_req = 1'b0;
      wait_resp(r0, "inv_fill_resp");
      @(negedge clk);
      count_low(n);
      total++;
      if (n != 16) begin bad++; $display("FAIL inv_fill_flush_len: ready low %0d cycles, required 16", n); end
      fetch(32'h8000_0118, 1'b0);
      wait_resp(r0 + 1, "inv_fill_refetch_resp");
      total++;
      if (bm_reqs != b0 + 2) begin bad++; $display("FAIL inv_fill_refills: got %0d, required 2", bm_reqs - b0); end
   endtask

   task automatic test_inv_with_hit();
      int n;
      fetch(32'h8000_0108, 1'b1);
      im_req_valid = 1'b0;
      inv_req = 1'b1;
      #1;
      total++;
      if (im_resp_valid !== 1'b1) begin bad++; $display("FAIL inv_hit_resp: got %b, required 1", im_resp_valid); end
      total++;
      if (im_req_ready !== 1'b0) begin bad++; $display("FAIL inv_hit_ready: got %b, required 0", im_req_ready); end
      @(negedge clk);
      inv_req = 1'b0;
      count_low(n);
      total++;
      if (n != 16) begin bad++; $display("FAIL inv_hit_flush_len: ready low %0d cycles, required 16", n); end
   endtask

   task automatic test_inv_same_cycle();
      int b0, r0, n;
      b0 = bm_reqs;
      r0 = resp_cnt;
      @(negedge clk);
      im_req_addr = 64'h8000_0000;
      im_req_valid = 1'b1;
      inv_req = 1'b1;
      #1;
      total++;
      if (im_req_ready !== 1'b0) begin bad++; $display("FAIL inv_same_ready: got %b, required 0", im_req_ready); end
      @(negedge clk);
      im_req_valid = 1'b0;
      inv_req = 1'b0;
      count_low(n);
      total++;
      if (n != 16) begin bad++; $display("FAIL inv_same_flush_len: ready low %0d cycles, required 16", n); end
      repeat (4) @(negedge clk);
      total++;
      if (resp_cnt != r0 || bm_reqs != b0) begin
         bad++;
         $display("FAIL inv_same_dropped: resp=%0d refills=%0d, required 0 and 0", resp_cnt - r0, bm_reqs - b0);
      end
   endtask

   task automatic test_reset_mid_fill();
      int b0, r0, n;
      logic [63:0] dropped;
      b0 = bm_reqs;
      r0 = resp_cnt;
      fetch(32'h8000_0310, 1'b0);
      wait_beat("rst_fill_beat");
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      dropped = exp_q.pop_back();
      count_low(n);
      total++;
      if (n != 16) begin bad++; $display("FAIL rst_fill_flush_len: ready low %0d cycles, required 16", n); end
      total++;
      if (resp_cnt != r0) begin bad++; $display("FAIL rst_fill_no_resp: got %0d responses, required 0 (dropped %h)", resp_cnt - r0, dropped); end
      fetch(32'h8000_0310, 1'b0);
      wait_resp(r0, "rst_fill_refetch_resp");
      total++;
      if (bm_reqs != b0 + 2) begin bad++; $display("FAIL rst_fill_refills: got %0d, required 2", bm_reqs - b0); end
   endtask

   initial begin
      fork
         monitor();
         responder();
      join_none
      test_reset();
      test_cold_miss();
      test_back_to_back();
      test_conflict();
      test_inv_during_fill();
      test_inv_with_hit();
      test_inv_same_cycle();
      test_reset_mid_fill();
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected: %0d outstanding, required 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
